// File: rtl/match_reporter_if.sv
// rtl/match_reporter_if.sv - match record stream between reporter and host
// Purpose: carries one {pe_idx, pos} match record per handshake.
// Signals:
//   m_valid   record available (reporter -> host)
//   m_ready   host accepts record (host -> reporter)
//   m_pe_idx  PE cell index of the match
//   m_pos     text position of the byte completing the match
interface match_reporter_if #(
    parameter int IDX_W = 4,
    parameter int POS_W = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [IDX_W-1:0] m_pe_idx;
    logic [POS_W-1:0] m_pos;

    modport master (output m_valid, output m_pe_idx, output m_pos, input m_ready);
    modport slave  (input m_valid, input m_pe_idx, input m_pos, output m_ready);
endinterface

// File: rtl/match_reporter.sv
// rtl/match_reporter.sv - turns PE array match flags into a buffered record stream
// Purpose: captures hit_vec & last_mask one cycle after each text byte, tags it
//   with the byte position, and emits one {pe_idx, pos} record per set bit
//   through a FIFO. The text stream is never back-pressured; a capture that
//   cannot be held is dropped and counted.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   clear          synchronous restart (flush, zero position/overflow/drop_cnt)
//   text_valid     a text byte entered the PE array this cycle
//   hit_vec        registered match flags of the PE cells
//   last_mask      cells holding the last byte of a pattern
//   m              record stream (master side)
//   busy           pending vector or FIFO non-empty
//   overflow       sticky capture-dropped flag
//   drop_cnt       saturating dropped-capture count
module match_reporter #(
    parameter int NPE        = 16,
    parameter int POS_W      = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int IDX_W = (NPE > 1) ? $clog2(NPE) : 1,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int REC_W = IDX_W + POS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                text_valid,
    input  logic [NPE-1:0]      hit_vec,
    input  logic [NPE-1:0]      last_mask,
    match_reporter_if.master    m,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_cnt_q, pos_cnt_d;
    logic                tv_q, tv_d;
    logic [POS_W-1:0]    cap_pos_q, cap_pos_d;
    logic [NPE-1:0]      pend_q, pend_d;
    logic [POS_W-1:0]    pend_pos_q, pend_pos_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [REC_W-1:0]    mem_q [FIFO_DEPTH];

    logic [IDX_W-1:0]    scan_idx;
    logic [NPE-1:0]      pend_after;
    logic [NPE-1:0]      cap;
    logic                push, pop, accept, drop, fifo_nonempty;
    logic [REC_W-1:0]    head;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty & m.m_ready;
    assign head          = mem_q[rd_ptr_q];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: stays in SCAN while any bit (old or newly accepted) is pending
    always_comb begin
        state_d = IDLE;
        if (pend_d != '0) state_d = SCAN;
    end

    // FSM outputs: lowest-set-bit scan and FIFO push decision
    always_comb begin
        scan_idx = '0;
        for (int i = NPE - 1; i >= 0; i--) begin
            if (pend_q[i]) scan_idx = IDX_W'(i);
        end
        // A full FIFO can still take a push when the head leaves this cycle
        push = (state_q == SCAN) &&
               ((count_q < (PTR_W+1)'(FIFO_DEPTH)) || pop);
        pend_after = pend_q;
        if (push) pend_after = pend_q & ~({{(NPE-1){1'b0}}, 1'b1} << scan_idx);
    end

    // Datapath next-state
    always_comb begin
        cap    = tv_q ? (hit_vec & last_mask) : '0;
        // Acceptance looks at pend after this cycle's scan, so a vector whose
        // last bit is being pushed right now frees the slot for the new capture
        accept = (cap != '0) && (pend_after == '0);
        drop   = (cap != '0) && (pend_after != '0);

        pos_cnt_d  = pos_cnt_q + POS_W'(text_valid);
        tv_d       = text_valid;
        cap_pos_d  = pos_cnt_q;
        pend_d     = accept ? cap : pend_after;
        pend_pos_d = accept ? cap_pos_q : pend_pos_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

        if (clear) begin
            pos_cnt_d  = '0;
            tv_d       = 1'b0;
            cap_pos_d  = '0;
            pend_d     = '0;
            pend_pos_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_cnt_q  <= '0;
            tv_q       <= 1'b0;
            cap_pos_q  <= '0;
            pend_q     <= '0;
            pend_pos_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pos_cnt_q  <= pos_cnt_d;
            tv_q       <= tv_d;
            cap_pos_q  <= cap_pos_d;
            pend_q     <= pend_d;
            pend_pos_q <= pend_pos_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) mem_q[wr_ptr_q] <= {scan_idx, pend_pos_q};
        end
    end

    // Head fields read as zero while the FIFO is empty
    assign m.m_valid  = fifo_nonempty;
    assign m.m_pe_idx = fifo_nonempty ? head[REC_W-1:POS_W] : '0;
    assign m.m_pos    = fifo_nonempty ? head[POS_W-1:0] : '0;
    assign busy       = (pend_q != '0) || fifo_nonempty;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_match_reporter.sv
// tb/tb_match_reporter.sv - scoreboard and table-driven bench for match_reporter
module tb_match_reporter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        text_valid = 1'b0;
    logic [15:0] hit_vec = '0;
    logic [15:0] last_mask = '0;
    logic        rdy = 1'b1;
    logic        rdy4 = 1'b0;
    logic        busy, overflow, busy4, overflow4;
    logic [7:0]  drop_cnt, drop_cnt4;

    match_reporter_if #(.IDX_W(4), .POS_W(16)) mi ();
    match_reporter_if #(.IDX_W(4), .POS_W(4))  mi4 ();
    assign mi.m_ready  = rdy;
    assign mi4.m_ready = rdy4;

    match_reporter #(.NPE(16), .POS_W(16), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .reset(rst_n), .clear(clear), .text_valid(text_valid),
        .hit_vec(hit_vec), .last_mask(last_mask), .m(mi.master),
        .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt));

    match_reporter #(.NPE(16), .POS_W(4), .FIFO_DEPTH(8)) u_dut4 (
        .clk(clk), .reset(rst_n), .clear(clear), .text_valid(text_valid),
        .hit_vec(hit_vec), .last_mask(last_mask), .m(mi4.master),
        .busy(busy4), .overflow(overflow4), .drop_cnt(drop_cnt4));

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] idx; logic [15:0] pos; } rec_t;
    typedef struct { logic [15:0] mask; logic [15:0] hit; int hit_byte; int exp_n; int exp_first; } vec_t;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   rec_cnt = 0;
    int   first_idx = -1;
    int   first_valid_cyc = -1;
    bit   mon_en = 1'b0;
    rec_t exp_q[$];
    int   pop_cyc[$];
    logic [15:0] hv [32];
    vec_t vecs [6];

    always @(posedge clk) cyc++;

    // Scoreboard: each accepted record must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && mon_en && mi.m_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mi.m_ready) begin
                rec_t e;
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_unexpected: got {%0d,%0d}, required none", mi.m_pe_idx, mi.m_pos);
                end else begin
                    e = exp_q.pop_front();
                    if (mi.m_pe_idx !== e.idx || mi.m_pos !== e.pos) begin
                        failed++;
                        $display("FAIL sb_record: got {%0d,%0d}, required {%0d,%0d}",
                                 mi.m_pe_idx, mi.m_pos, e.idx, e.pos);
                    end
                end
                rec_cnt++;
                if (rec_cnt == 1) first_idx = int'(mi.m_pe_idx);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic clr_hv();
        for (int i = 0; i < 32; i++) hv[i] = '0;
    endtask

    // Bytes 0..n-1 one per cycle; hv[b] is presented the cycle after byte b
    task automatic run_bytes(input int n);
        for (int c = 0; c <= n; c++) begin
            text_valid = (c < n);
            hit_vec    = (c > 0) ? hv[c-1] : 16'h0;
            tick();
        end
        text_valid = 1'b0;
        hit_vec    = '0;
    endtask

    task automatic reset_sb();
        exp_q.delete();
        pop_cyc.delete();
        rec_cnt = 0;
        first_idx = -1;
        first_valid_cyc = -1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, (n < 100) ? 1 : 0, 1);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic push_exp(input int idx, input int pos);
        rec_t r;
        r.idx = 4'(idx);
        r.pos = 16'(pos);
        exp_q.push_back(r);
    endtask

    initial begin
        int n;
        vecs[0] = '{mask: 16'h00F0, hit: 16'h0030, hit_byte: 2, exp_n: 2, exp_first: 4};
        vecs[1] = '{mask: 16'hFFFF, hit: 16'h8000, hit_byte: 0, exp_n: 1, exp_first: 15};
        vecs[2] = '{mask: 16'h0F0F, hit: 16'hF0F0, hit_byte: 1, exp_n: 0, exp_first: -1};
        vecs[3] = '{mask: 16'hFFFF, hit: 16'h0000, hit_byte: 3, exp_n: 0, exp_first: -1};
        vecs[4] = '{mask: 16'hAAAA, hit: 16'hFFFF, hit_byte: 5, exp_n: 8, exp_first: 1};
        vecs[5] = '{mask: 16'h0001, hit: 16'h0001, hit_byte: 9, exp_n: 1, exp_first: 0};

        clr_hv();
        #12;
        chk("rst_m_valid", mi.m_valid, 0);
        chk("rst_m_pe_idx", mi.m_pe_idx, 0);
        chk("rst_m_pos", mi.m_pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Table-driven single-capture vectors; model expands bits lowest first
        foreach (vecs[v]) begin
            last_mask = vecs[v].mask;
            do_clear();
            reset_sb();
            clr_hv();
            hv[vecs[v].hit_byte] = vecs[v].hit;
            for (int b = 0; b < 16; b++)
                if (vecs[v].hit[b] && vecs[v].mask[b]) push_exp(b, vecs[v].hit_byte);
            run_bytes(vecs[v].hit_byte + 1);
            drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_count", v), rec_cnt, vecs[v].exp_n);
            chk($sformatf("vec%0d_first", v), first_idx, vecs[v].exp_first);
            chk($sformatf("vec%0d_overflow", v), overflow, 0);
        end

        // T1: latency byte -> m_valid is 3 cycles
        last_mask = 16'h0004;
        do_clear(); reset_sb(); clr_hv();
        hv[3] = 16'h0004;
        push_exp(2, 3);
        begin
            int byte3_cyc;
            byte3_cyc = -1;
            for (int c = 0; c <= 6; c++) begin
                text_valid = (c < 6);
                hit_vec = (c > 0) ? hv[c-1] : 16'h0;
                if (c == 3) byte3_cyc = cyc;
                tick();
            end
            text_valid = 1'b0; hit_vec = '0;
            drain("t1");
            chk("t1_latency", first_valid_cyc - byte3_cyc, 3);
        end

        // T2: three records on consecutive cycles, busy falls right after the last
        last_mask = 16'h8011;
        do_clear(); reset_sb(); clr_hv();
        hv[7] = 16'h8011;
        push_exp(0, 7); push_exp(4, 7); push_exp(15, 7);
        run_bytes(8);
        n = 0;
        while (pop_cyc.size() < 3 && n < 50) begin tick(); n++; end
        chk("t2_three_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("t2_back_to_back", pop_cyc[2] - pop_cyc[0], 2);
            n = 0;
            while (busy && n < 20) begin @(negedge clk); n++; end
            chk("t2_busy_fall", cyc - pop_cyc[2], 1);
        end
        drain("t2");

        // T3: FIFO full with m_ready low stalls the scan without loss
        rdy = 1'b0;
        last_mask = 16'h0001;
        do_clear(); reset_sb(); clr_hv();
        for (int b = 0; b < 9; b++) begin hv[b] = 16'h0001; push_exp(0, b); end
        run_bytes(9);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_valid_stall", mi.m_valid, 1);
        chk("t3_head_pos", mi.m_pos, 0);
        chk("t3_busy", busy, 1);
        chk("t3_no_overflow", overflow, 0);
        rdy = 1'b1;
        drain("t3");
        chk("t3_count", rec_cnt, 9);
        chk("t3_drop_cnt", drop_cnt, 0);

        // T4: capture while pend stays non-zero is dropped
        last_mask = 16'h0103;
        do_clear(); reset_sb(); clr_hv();
        hv[4] = 16'h0003; hv[5] = 16'h0100;
        push_exp(0, 4); push_exp(1, 4);
        run_bytes(6);
        drain("t4");
        chk("t4_count", rec_cnt, 2);
        chk("t4_overflow", overflow, 1);
        chk("t4_drop_cnt", drop_cnt, 1);
        do_clear();
        chk("t4_clr_overflow", overflow, 0);
        chk("t4_clr_drop_cnt", drop_cnt, 0);

        // T5: capture accepted in the cycle the scan clears the last bit
        last_mask = 16'h0101;
        do_clear(); reset_sb(); clr_hv();
        hv[4] = 16'h0001; hv[5] = 16'h0100;
        push_exp(0, 4); push_exp(8, 5);
        run_bytes(6);
        drain("t5");
        chk("t5_count", rec_cnt, 2);
        chk("t5_overflow", overflow, 0);

        // T6: position wrap on the 4-bit instance, then clear with records queued
        mon_en = 1'b0;
        rdy4 = 1'b0;
        last_mask = 16'h0001;
        do_clear(); reset_sb(); clr_hv();
        hv[16] = 16'h0001;
        run_bytes(17);
        n = 0;
        while (!mi4.m_valid && n < 20) begin tick(); n++; end
        chk("t6_wrap_valid", mi4.m_valid, 1);
        chk("t6_wrap_pos", mi4.m_pos, 0);
        chk("t6_wrap_idx", mi4.m_pe_idx, 0);
        clr_hv();
        hv[0] = 16'h0001; hv[1] = 16'h0001;
        run_bytes(2);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_queued_valid", mi4.m_valid, 1);
        chk("t6_queued_pos", mi4.m_pos, 0);
        clear = 1'b1;
        tick();
        chk("t6_clr_valid", mi4.m_valid, 0);
        chk("t6_clr_busy", busy4, 0);
        chk("t6_clr_drop_cnt", drop_cnt4, 0);
        clear = 1'b0;

        // Async reset mid-scan after a drop
        rdy = 1'b0;
        last_mask = 16'hFFFF;
        do_clear(); reset_sb(); clr_hv();
        hv[0] = 16'hFFFF; hv[12] = 16'h0001;
        run_bytes(13);
        tick();
        chk("ar_pre_overflow", overflow, 1);
        chk("ar_pre_drop_cnt", drop_cnt, 1);
        chk("ar_pre_busy", busy, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_m_valid", mi.m_valid, 0);
        chk("ar_m_pe_idx", mi.m_pe_idx, 0);
        chk("ar_m_pos", mi.m_pos, 0);
        chk("ar_busy", busy, 0);
        chk("ar_overflow", overflow, 0);
        chk("ar_drop_cnt", drop_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
